// File: rtl/turn_resource_accum_pkg.sv
// Shared game definitions: card mode codes and the draw FSM state encoding.
package turn_resource_accum_pkg;

   localparam logic [2:0] MODE_NONE      = 3'd0;
   localparam logic [2:0] MODE_START     = 3'd1;
   localparam logic [2:0] MODE_ACTION    = 3'd2;
   localparam logic [2:0] MODE_ACTIONEND = 3'd3;
   localparam logic [2:0] MODE_BUY       = 3'd4;
   localparam logic [2:0] MODE_DRAW      = 3'd5;
   localparam logic [2:0] MODE_ENDGAME   = 3'd6;
   localparam logic [2:0] MODE_RSVD      = 3'd7;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_DRAW = 1'b1
   } state_t;

endpackage

// File: rtl/turn_resource_accum_sat_addsub.sv
// Saturating add/subtract, signed or unsigned, of two equal-width operands.
module sat_addsub #(
   parameter int W      = 4,
   parameter bit SIGNED = 1'b0
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         sub,
   output logic [W-1:0] y
);

   logic [W:0] ext_a;
   logic [W:0] ext_b;
   logic [W:0] s;

   always_comb begin
      ext_a = SIGNED ? {a[W-1], a} : {1'b0, a};
      ext_b = SIGNED ? {b[W-1], b} : {1'b0, b};
      s     = sub ? (ext_a - ext_b) : (ext_a + ext_b);
      y     = s[W-1:0];
      if (SIGNED) begin
         // sign bits disagree only on overflow; s[W] holds the true sign
         if (s[W] != s[W-1])
            y = s[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      end else if (s[W]) begin
         y = sub ? '0 : '1;
      end
   end

endmodule

// File: rtl/turn_resource_accum.sv
// Per-turn resource bookkeeping: applies card stats, sequences pending draws,
// and keeps per-player VP totals.
//   state | meaning
//   IDLE  | ready for a card
//   DRAW  | requesting cards until pending draws reach zero
module turn_resource_accum
   import turn_resource_accum_pkg::*;
#(
   parameter  int CNT_W    = 3,
   parameter  int GOLD_W   = 5,
   parameter  int COST_W   = 4,
   parameter  int VP_W     = 4,
   parameter  int NPLAYERS = 4,
   localparam int PW       = (NPLAYERS > 1) ? $clog2(NPLAYERS) : 1,
   localparam int VPT      = VP_W + 3
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [2:0]              mode,
   input  logic                    card_valid,
   output logic                    card_ready,
   input  logic [CNT_W-1:0]        ibuy,
   input  logic [CNT_W-1:0]        iaction,
   input  logic [CNT_W-1:0]        idraw,
   input  logic [GOLD_W-1:0]       igold,
   input  logic [COST_W-1:0]       icost,
   input  logic [VP_W-1:0]         ivp,
   input  logic [PW-1:0]           player,
   output logic                    draw_req,
   input  logic                    draw_ack,
   output logic [CNT_W-1:0]        buys,
   output logic [CNT_W-1:0]        actions,
   output logic [GOLD_W-1:0]       gold,
   output logic [NPLAYERS*VPT-1:0] vp_bus,
   output logic                    ok,
   output logic                    rej
);

   state_t                  state_q, state_n;
   logic [CNT_W-1:0]        actions_q, actions_n, buys_q, buys_n, pending_q, pending_n;
   logic [GOLD_W-1:0]       gold_q, gold_n;
   logic [VPT-1:0]          vp_q [NPLAYERS];
   logic [VPT-1:0]          vp_n [NPLAYERS];
   logic                    ok_n, rej_n;

   logic [CNT_W-1:0]        act_dec, act_sum, buy_sum, buy_dec, pend_sum, pend_dec;
   logic [GOLD_W-1:0]       gold_sum, gold_diff, cost_ext;
   logic [GOLD_W+COST_W-1:0] cost_wide, gold_wide;
   logic [VPT-1:0]          vp_sel, vp_sum, ivp_ext;
   logic                    gold_ge, player_ok, accept;

   assign cost_wide = {{GOLD_W{1'b0}}, icost};
   assign gold_wide = {{COST_W{1'b0}}, gold_q};
   assign cost_ext  = cost_wide[GOLD_W-1:0];
   assign gold_ge   = gold_wide >= cost_wide;
   assign ivp_ext   = {{3{ivp[VP_W-1]}}, ivp};
   assign player_ok = 32'(player) < NPLAYERS;

   sat_addsub #(.W(CNT_W))  u_act_dec  (.a(actions_q), .b(CNT_W'(1)), .sub(1'b1), .y(act_dec));
   sat_addsub #(.W(CNT_W))  u_act_add  (.a(act_dec),   .b(iaction),   .sub(1'b0), .y(act_sum));
   sat_addsub #(.W(CNT_W))  u_buy_add  (.a(buys_q),    .b(ibuy),      .sub(1'b0), .y(buy_sum));
   sat_addsub #(.W(CNT_W))  u_buy_dec  (.a(buys_q),    .b(CNT_W'(1)), .sub(1'b1), .y(buy_dec));
   sat_addsub #(.W(CNT_W))  u_pend_add (.a(pending_q), .b(idraw),     .sub(1'b0), .y(pend_sum));
   sat_addsub #(.W(CNT_W))  u_pend_dec (.a(pending_q), .b(CNT_W'(1)), .sub(1'b1), .y(pend_dec));
   sat_addsub #(.W(GOLD_W)) u_gold_add (.a(gold_q),    .b(igold),     .sub(1'b0), .y(gold_sum));
   sat_addsub #(.W(GOLD_W)) u_gold_sub (.a(gold_q),    .b(cost_ext),  .sub(1'b1), .y(gold_diff));
   sat_addsub #(.W(VPT), .SIGNED(1'b1)) u_vp_add (.a(vp_sel), .b(ivp_ext), .sub(1'b0), .y(vp_sum));

   assign accept = card_valid && (state_q == ST_IDLE);

   always_comb begin
      state_n   = state_q;
      actions_n = actions_q;
      buys_n    = buys_q;
      gold_n    = gold_q;
      pending_n = pending_q;
      vp_n      = vp_q;
      ok_n      = 1'b0;
      rej_n     = 1'b0;
      vp_sel    = '0;
      for (int i = 0; i < NPLAYERS; i++)
         if (PW'(i) == player) vp_sel = vp_q[i];

      if (accept) begin
         ok_n = 1'b1;
         case (mode)
            MODE_START: begin
               actions_n = CNT_W'(1);
               buys_n    = CNT_W'(1);
               gold_n    = '0;
               pending_n = '0;
            end
            MODE_ACTION: begin
               if (actions_q == '0) begin
                  ok_n  = 1'b0;
                  rej_n = 1'b1;
               end else begin
                  actions_n = act_sum;
                  buys_n    = buy_sum;
                  gold_n    = gold_sum;
                  pending_n = pend_sum;
               end
            end
            MODE_ACTIONEND: gold_n = gold_sum;
            MODE_BUY: begin
               if ((buys_q != '0) && gold_ge) begin
                  gold_n = gold_diff;
                  buys_n = buy_dec;
               end else begin
                  ok_n  = 1'b0;
                  rej_n = 1'b1;
               end
            end
            MODE_DRAW: pending_n = pend_sum;
            MODE_ENDGAME: begin
               if (player_ok) begin
                  for (int i = 0; i < NPLAYERS; i++)
                     if (PW'(i) == player) vp_n[i] = vp_sum;
               end else begin
                  ok_n  = 1'b0;
                  rej_n = 1'b1;
               end
            end
            default: begin
               ok_n  = 1'b0;
               rej_n = 1'b1;
            end
         endcase
         if (ok_n && (pending_n != '0)) state_n = ST_DRAW;
      end else if ((state_q == ST_DRAW) && draw_ack) begin
         pending_n = pend_dec;
         if (pend_dec == '0) state_n = ST_IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         actions_q <= '0;
         buys_q    <= '0;
         gold_q    <= '0;
         pending_q <= '0;
         ok        <= 1'b0;
         rej       <= 1'b0;
         for (int i = 0; i < NPLAYERS; i++) vp_q[i] <= '0;
      end else begin
         state_q   <= state_n;
         actions_q <= actions_n;
         buys_q    <= buys_n;
         gold_q    <= gold_n;
         pending_q <= pending_n;
         ok        <= ok_n;
         rej       <= rej_n;
         vp_q      <= vp_n;
      end
   end

   always_comb begin
      vp_bus = '0;
      for (int i = 0; i < NPLAYERS; i++) vp_bus[i*VPT +: VPT] = vp_q[i];
   end

   assign card_ready = (state_q == ST_IDLE);
   assign draw_req   = (state_q == ST_DRAW);
   assign actions    = actions_q;
   assign buys       = buys_q;
   assign gold       = gold_q;

endmodule

// File: tb/tb_turn_resource_accum.sv
// Directed bench for turn_resource_accum: vector table plus draw/VP/reset sequences.
module tb_turn_resource_accum;

   localparam int CNT_W = 3, GOLD_W = 5, COST_W = 4, VP_W = 4, NP = 3, PW = 2, VPT = 7;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [2:0]        mode = '0;
   logic              card_valid = 1'b0;
   logic              card_ready;
   logic [CNT_W-1:0]  ibuy = '0, iaction = '0, idraw = '0;
   logic [GOLD_W-1:0] igold = '0;
   logic [COST_W-1:0] icost = '0;
   logic [VP_W-1:0]   ivp = '0;
   logic [PW-1:0]     player = '0;
   logic              draw_req;
   logic              draw_ack = 1'b0;
   logic [CNT_W-1:0]  buys, actions;
   logic [GOLD_W-1:0] gold;
   logic [NP*VPT-1:0] vp_bus;
   logic              ok, rej;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   turn_resource_accum #(.CNT_W(CNT_W), .GOLD_W(GOLD_W), .COST_W(COST_W),
                         .VP_W(VP_W), .NPLAYERS(NP)) dut (
      .clk(clk), .rst_n(rst_n), .mode(mode), .card_valid(card_valid),
      .card_ready(card_ready), .ibuy(ibuy), .iaction(iaction), .idraw(idraw),
      .igold(igold), .icost(icost), .ivp(ivp), .player(player),
      .draw_req(draw_req), .draw_ack(draw_ack), .buys(buys), .actions(actions),
      .gold(gold), .vp_bus(vp_bus), .ok(ok), .rej(rej));

   typedef struct {
      int mode; int ibuy; int iaction; int idraw; int igold; int icost;
      int exp_ok; int exp_rej; int exp_act; int exp_buys; int exp_gold;
   } vec_t;

   vec_t vecs [17];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int get_vp(input int p);
      logic [NP*VPT-1:0] b;
      logic [VPT-1:0]    v;
      b = vp_bus;
      v = b[p*VPT +: VPT];
      return int'($signed(v));
   endfunction

   task automatic set_card(input int m, input int b, input int a, input int d,
                           input int g, input int c, input int v, input int p);
      mode = 3'(m); ibuy = CNT_W'(b); iaction = CNT_W'(a); idraw = CNT_W'(d);
      igold = GOLD_W'(g); icost = COST_W'(c); ivp = VP_W'(v); player = PW'(p);
   endtask

   // presents a card for one edge; outputs are sampled #1 after that edge
   task automatic apply(input int m, input int b, input int a, input int d,
                        input int g, input int c, input int v, input int p);
      @(negedge clk);
      set_card(m, b, a, d, g, c, v, p);
      card_valid = 1'b1;
      @(posedge clk);
      #1;
      card_valid = 1'b0;
   endtask

   initial begin
      //           mode b a d  g  c  ok rej act buy gold
      vecs[0]  = '{0, 0,0,0, 0, 0, 0, 1, 0, 0, 0};
      vecs[1]  = '{2, 0,0,0, 0, 0, 0, 1, 0, 0, 0};
      vecs[2]  = '{1, 0,0,0, 0, 0, 1, 0, 1, 1, 0};
      vecs[3]  = '{2, 1,2,0, 3, 0, 1, 0, 2, 2, 3};
      vecs[4]  = '{4, 0,0,0, 0, 5, 0, 1, 2, 2, 3};
      vecs[5]  = '{4, 0,0,0, 0, 3, 1, 0, 2, 1, 0};
      vecs[6]  = '{3, 0,0,0, 7, 0, 1, 0, 2, 1, 7};
      vecs[7]  = '{4, 0,0,0, 0, 2, 1, 0, 2, 0, 5};
      vecs[8]  = '{4, 0,0,0, 0, 0, 0, 1, 2, 0, 5};
      vecs[9]  = '{7, 0,0,0, 0, 0, 0, 1, 2, 0, 5};
      vecs[10] = '{2, 7,7,0,31, 0, 1, 0, 7, 7,31};
      vecs[11] = '{3, 0,0,0, 5, 0, 1, 0, 7, 7,31};
      vecs[12] = '{1, 0,0,0, 0, 0, 1, 0, 1, 1, 0};
      vecs[13] = '{3, 0,0,0,30, 0, 1, 0, 1, 1,30};
      vecs[14] = '{3, 0,0,0, 5, 0, 1, 0, 1, 1,31};
      vecs[15] = '{2, 0,0,0, 0, 0, 1, 0, 0, 1,31};
      vecs[16] = '{2, 0,0,0, 0, 0, 0, 1, 0, 1,31};

      repeat (2) @(posedge clk);
      #1;
      check("rst_actions", int'(actions), 0);
      check("rst_buys", int'(buys), 0);
      check("rst_gold", int'(gold), 0);
      check("rst_vp_bus", int'(vp_bus), 0);
      check("rst_draw_req", int'(draw_req), 0);
      check("rst_ok_rej", int'({ok, rej}), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("rst_card_ready", int'(card_ready), 1);

      for (int i = 0; i < 17; i++) begin
         apply(vecs[i].mode, vecs[i].ibuy, vecs[i].iaction, vecs[i].idraw,
               vecs[i].igold, vecs[i].icost, 0, 0);
         check($sformatf("vec%0d_ok", i), int'(ok), vecs[i].exp_ok);
         check($sformatf("vec%0d_rej", i), int'(rej), vecs[i].exp_rej);
         check($sformatf("vec%0d_actions", i), int'(actions), vecs[i].exp_act);
         check($sformatf("vec%0d_buys", i), int'(buys), vecs[i].exp_buys);
         check($sformatf("vec%0d_gold", i), int'(gold), vecs[i].exp_gold);
         check($sformatf("vec%0d_ready", i), int'(card_ready), 1);
      end
      @(posedge clk);
      #1;
      check("ok_is_pulse", int'({ok, rej}), 0);

      // draw sequencing with a card held off while drawing
      apply(1, 0,0,0, 0, 0, 0, 0);
      apply(2, 1,2,2, 2, 0, 0, 0);
      check("draw_act", int'(actions), 2);
      check("draw_buys", int'(buys), 2);
      check("draw_gold", int'(gold), 2);
      check("draw_req_hi", int'(draw_req), 1);
      check("draw_ready_lo", int'(card_ready), 0);
      @(negedge clk);
      set_card(3, 0,0,0, 1, 0, 0, 0);
      card_valid = 1'b1;
      @(posedge clk);
      #1;
      check("held_no_ok", int'(ok), 0);
      check("held_gold", int'(gold), 2);
      @(negedge clk);
      draw_ack = 1'b1;
      @(posedge clk);
      #1;
      check("draw_after1", int'(draw_req), 1);
      @(posedge clk);
      #1;
      check("draw_after2_req", int'(draw_req), 0);
      check("draw_after2_ready", int'(card_ready), 1);
      check("draw_after2_ok", int'(ok), 0);
      @(negedge clk);
      draw_ack = 1'b0;
      @(posedge clk);
      #1;
      card_valid = 1'b0;
      check("held_applied_ok", int'(ok), 1);
      check("held_applied_gold", int'(gold), 3);
      // stray acks in IDLE must not disturb anything
      @(negedge clk);
      draw_ack = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      draw_ack = 1'b0;
      check("idle_ack_ignored", int'(draw_req), 0);

      // VP accumulation and saturation
      for (int k = 0; k < 3; k++) apply(6, 0,0,0, 0, 0, -1, 1);
      apply(6, 0,0,0, 0, 0, 6, 1);
      check("vp1_ok", int'(ok), 1);
      check("vp1_total", get_vp(1), 3);
      check("vp0_untouched", get_vp(0), 0);
      apply(6, 0,0,0, 0, 0, 1, 3);
      check("vp_bad_player_rej", int'(rej), 1);
      check("vp_bad_player_ok", int'(ok), 0);
      check("vp_bad_player_v2", get_vp(2), 0);
      for (int k = 0; k < 10; k++) apply(6, 0,0,0, 0, 0, 7, 0);
      check("vp0_sat_max", get_vp(0), 63);
      for (int k = 0; k < 20; k++) apply(6, 0,0,0, 0, 0, -8, 2);
      check("vp2_sat_min", get_vp(2), -64);
      check("vp1_kept", get_vp(1), 3);

      // asynchronous reset in the middle of a draw burst
      apply(1, 0,0,0, 0, 0, 0, 0);
      apply(3, 0,0,0, 4, 0, 0, 0);
      apply(5, 0,0,3, 0, 0, 0, 0);
      check("pre_rst_draw_req", int'(draw_req), 1);
      check("pre_rst_gold", int'(gold), 4);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_draw_req", int'(draw_req), 0);
      check("mid_rst_actions", int'(actions), 0);
      check("mid_rst_buys", int'(buys), 0);
      check("mid_rst_gold", int'(gold), 0);
      check("mid_rst_vp", int'(vp_bus), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("post_rst_ready", int'(card_ready), 1);
      apply(5, 0,0,1, 0, 0, 0, 0);
      check("post_rst_draw_req", int'(draw_req), 1);
      @(negedge clk);
      draw_ack = 1'b1;
      @(posedge clk);
      #1;
      draw_ack = 1'b0;
      check("post_rst_pending_cleared", int'(draw_req), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
